// File: rtl/decode_pkg.sv
// RV32I decode constants and the decoded-bundle type shared by decode_comb and
// decode_queue_stage.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [9:0] ALU_ADD  = 10'b0000000_000;
  localparam logic [9:0] ALU_SUB  = 10'b0100000_000;
  localparam logic [9:0] ALU_SLT  = 10'b0000000_010;
  localparam logic [9:0] ALU_SLTU = 10'b0000000_011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] JAL_BITS  = 3'b010;
  localparam logic [2:0] JALR_BITS = 3'b011;
  localparam logic       STORE_BIT = 1'b1;
  localparam logic       LOAD_BIT  = 1'b0;

  // Immediates are kept at instruction width; the stage widens them to XLEN.
  typedef struct packed {
    logic [9:0]  alu_ctrl;
    logic [31:0] imm;
    logic [5:0]  sel_a;
    logic [4:0]  sel_b;
    logic [5:0]  sel_out;
    logic        imm_en;
    logic [2:0]  jmp_type;
    logic [31:0] jmp_imm;
    logic        new_jmp;
    logic [5:0]  jal_rs;
    logic [8:0]  lam_control;
    logic        lam_new;
    logic        illegal;
  } dec_bundle_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I instruction -> decoded bundle.
// DECODE_ILLEGAL_TRAP_EN: flag unknown opcodes / bad R-type funct7 as illegal.
module decode_comb
  import decode_pkg::*;
#(
  parameter int PC_IDX = 32
) (
  input  logic [31:0] i_instr,
  output dec_bundle_t o_bundle
);

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [5:0]  w_pc_sel;

  assign w_op     = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_f3     = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_f7     = i_instr[31:25];
  assign w_pc_sel = 6'(PC_IDX);

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    o_bundle = '0;
    case (w_op)
      OP_R: begin
        o_bundle.sel_a    = {1'b0, w_rs1};
        o_bundle.sel_b    = w_rs2;
        o_bundle.sel_out  = {1'b0, w_rd};
        o_bundle.alu_ctrl = {w_f7, w_f3};
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (w_f7 != F7_BASE && w_f7 != F7_ALT) begin
          o_bundle.illegal = 1'b1;
          o_bundle.sel_out = '0;
        end
`endif
      end
      OP_B: begin
        o_bundle.sel_a    = {1'b0, w_rs1};
        o_bundle.sel_b    = w_rs2;
        o_bundle.imm      = w_imm_b;
        o_bundle.jmp_imm  = w_imm_b;
        o_bundle.jmp_type = w_f3;
        o_bundle.new_jmp  = 1'b1;
        case (w_f3)
          F3_BEQ,  F3_BNE:  o_bundle.alu_ctrl = ALU_SUB;
          F3_BLT,  F3_BGE:  o_bundle.alu_ctrl = ALU_SLT;
          F3_BLTU, F3_BGEU: o_bundle.alu_ctrl = ALU_SLTU;
          default:          o_bundle.alu_ctrl = ALU_ADD;
        endcase
      end
      OP_S: begin
        o_bundle.sel_a       = {1'b0, w_rs1};
        o_bundle.sel_b       = w_rs2;
        o_bundle.imm         = w_imm_s;
        o_bundle.imm_en      = 1'b1;
        o_bundle.lam_control = {STORE_BIT, w_f3, w_rs2};
      end
      OP_LUI, OP_AUIPC: begin
        o_bundle.sel_a   = (w_op == OP_AUIPC) ? w_pc_sel : 6'd0;
        o_bundle.imm     = w_imm_u;
        o_bundle.imm_en  = 1'b1;
        o_bundle.sel_out = {1'b0, w_rd};
      end
      // Link value is computed as PC + (-4) by the ALU; the target goes to the jump unit.
      OP_JAL, OP_JALR: begin
        o_bundle.sel_a    = w_pc_sel;
        o_bundle.imm      = 32'hFFFF_FFFC;
        o_bundle.imm_en   = 1'b1;
        o_bundle.sel_out  = {1'b0, w_rd};
        o_bundle.new_jmp  = 1'b1;
        o_bundle.jmp_type = (w_op == OP_JAL) ? JAL_BITS : JALR_BITS;
        o_bundle.jmp_imm  = (w_op == OP_JAL) ? w_imm_j : w_imm_i;
        o_bundle.jal_rs   = (w_op == OP_JAL) ? w_pc_sel : {1'b0, w_rs1};
      end
      OP_LOAD: begin
        o_bundle.sel_a       = {1'b0, w_rs1};
        o_bundle.imm         = w_imm_i;
        o_bundle.imm_en      = 1'b1;
        o_bundle.sel_out     = {1'b0, w_rd};
        o_bundle.lam_new     = 1'b1;
        o_bundle.lam_control = {LOAD_BIT, w_f3, w_rd};
      end
      OP_OPIMM: begin
        o_bundle.sel_a    = {1'b0, w_rs1};
        o_bundle.imm      = w_imm_i;
        o_bundle.imm_en   = 1'b1;
        o_bundle.sel_out  = {1'b0, w_rd};
        o_bundle.alu_ctrl = {w_f7, w_f3};
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        o_bundle.illegal = 1'b1;
`else
        o_bundle.illegal = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Buffered decode stage: instruction FIFO, registered decoded bundle, jump-wait FSM.
// Illegal-instruction trapping is enabled with DECODE_ILLEGAL_TRAP_EN (see decode_comb).
module decode_queue_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4,
  parameter int PC_IDX = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic                      flush,
  input  logic                      jmp_resolve,
  input  logic                      jmp_taken,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [9:0]                alu_ctrl,
  output logic [XLEN-1:0]           imm,
  output logic [5:0]                sel_a,
  output logic [4:0]                sel_b,
  output logic [5:0]                sel_out,
  output logic                      imm_en,
  output logic [2:0]                jmp_type,
  output logic [XLEN-1:0]           jmp_imm,
  output logic                      new_jmp,
  output logic [5:0]                jal_rs,
  output logic [8:0]                lam_control,
  output logic                      lam_new,
  output logic                      illegal,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] QD = (AW+1)'(QDEPTH);
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_WAIT_JMP = 1'b1;

  logic [31:0]   r_mem [QDEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [0:0]    r_state;
  logic          r_out_valid;
  dec_bundle_t   r_bundle, w_dec;
  logic [31:0]   w_head;
  logic          w_wr, w_load, w_jclr;

  function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign w_head = r_mem[r_rptr];
  assign w_jclr = (r_state == ST_WAIT_JMP) && jmp_resolve && jmp_taken;
  assign in_ready = (r_count < QD);
  // flush and a taken-jump clear both drop any same-cycle write.
  assign w_wr   = in_valid && in_ready && !flush && !w_jclr;
  assign w_load = (r_state == ST_RUN) && (r_count != '0) && (!r_out_valid || out_ready) && !flush;

  decode_comb #(.PC_IDX(PC_IDX)) u_dec (
    .i_instr  (w_head),
    .o_bundle (w_dec)
  );

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_state     <= ST_RUN;
      r_out_valid <= 1'b0;
    end else begin
      if (flush || w_jclr) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_wr)   r_wptr <= r_wptr + AW'(1);
        if (w_load) r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_load);
      end

      if (flush)          r_out_valid <= 1'b0;
      else if (w_load)    r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;

      if (flush)                                       r_state <= ST_RUN;
      else if (w_load && w_dec.new_jmp)                r_state <= ST_WAIT_JMP;
      else if (r_state == ST_WAIT_JMP && jmp_resolve)  r_state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_bundle <= '0;
    else if (w_load) r_bundle <= w_dec;
  end

  assign out_valid   = r_out_valid;
  assign q_count     = r_count;
  assign alu_ctrl    = r_bundle.alu_ctrl;
  assign imm         = sext_xlen(r_bundle.imm);
  assign sel_a       = r_bundle.sel_a;
  assign sel_b       = r_bundle.sel_b;
  assign sel_out     = r_bundle.sel_out;
  assign imm_en      = r_bundle.imm_en;
  assign jmp_type    = r_bundle.jmp_type;
  assign jmp_imm     = sext_xlen(r_bundle.jmp_imm);
  assign new_jmp     = r_bundle.new_jmp;
  assign jal_rs      = r_bundle.jal_rs;
  assign lam_control = r_bundle.lam_control;
  assign lam_new     = r_bundle.lam_new;
  assign illegal     = r_bundle.illegal;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Self-checking bench for decode_queue_stage: directed scenarios plus a randomized
// run against a queue-based reference model. Honours DECODE_ILLEGAL_TRAP_EN.
module tb_decode_queue_stage;

  localparam int QD = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, jmp_resolve = 1'b0, jmp_taken = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid, imm_en, new_jmp, lam_new, illegal;
  logic [9:0]  alu_ctrl;
  logic [31:0] imm, jmp_imm;
  logic [5:0]  sel_a, sel_out, jal_rs;
  logic [4:0]  sel_b;
  logic [2:0]  jmp_type;
  logic [8:0]  lam_control;
  logic [2:0]  q_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0]  alu;
    logic [31:0] imm;
    logic [5:0]  sa;
    logic [4:0]  sb;
    logic [5:0]  so;
    logic        ie;
    logic [2:0]  jt;
    logic [31:0] ji;
    logic        nj;
    logic [5:0]  jr;
    logic [8:0]  lc;
    logic        ln;
    logic        il;
  } exp_t;

  exp_t act;
  assign act = {alu_ctrl, imm, sel_a, sel_b, sel_out, imm_en, jmp_type, jmp_imm,
                new_jmp, jal_rs, lam_control, lam_new, illegal};

  // Reference model state
  logic [31:0] mq[$];
  bit          m_ov, m_wj;
  logic [31:0] m_ob;

  decode_queue_stage #(.XLEN(32), .QDEPTH(QD), .PC_IDX(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .jmp_resolve(jmp_resolve), .jmp_taken(jmp_taken),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl), .imm(imm),
    .sel_a(sel_a), .sel_b(sel_b), .sel_out(sel_out), .imm_en(imm_en), .jmp_type(jmp_type),
    .jmp_imm(jmp_imm), .new_jmp(new_jmp), .jal_rs(jal_rs), .lam_control(lam_control),
    .lam_new(lam_new), .illegal(illegal), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Expected decode derived from the instruction-format rules with integer arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    int x, op, rd, f3, rs1, rs2, f7, ii, is, ib, iu, ij;
    e = '0;
    x = w;
    op = x & 127;          rd  = (x >> 7) & 31;  f3 = (x >> 12) & 7;
    rs1 = (x >> 15) & 31;  rs2 = (x >> 20) & 31; f7 = (x >> 25) & 127;
    ii = x >>> 20;
    is = (x >>> 25) * 32 + rd;
    ib = (x >>> 31) * 4096 + ((x >> 7) & 1) * 2048 + ((x >> 25) & 63) * 32 + ((x >> 8) & 15) * 2;
    iu = x - (x & 4095);
    ij = (x >>> 31) * 1048576 + ((x >> 12) & 255) * 4096 + ((x >> 20) & 1) * 2048 + ((x >> 21) & 1023) * 2;
    case (op)
      'h33: begin
        e.sa = 6'(rs1); e.sb = 5'(rs2); e.so = 6'(rd); e.alu = 10'(f7 * 8 + f3);
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (f7 != 0 && f7 != 32) begin e.il = 1'b1; e.so = 6'd0; end
`endif
      end
      'h63: begin
        e.sa = 6'(rs1); e.sb = 5'(rs2); e.imm = 32'(ib); e.ji = 32'(ib); e.nj = 1'b1; e.jt = 3'(f3);
        if (f3 < 2) e.alu = 10'd256;
        else if (f3 == 4 || f3 == 5) e.alu = 10'd2;
        else if (f3 >= 6) e.alu = 10'd3;
      end
      'h23: begin
        e.sa = 6'(rs1); e.sb = 5'(rs2); e.imm = 32'(is); e.ie = 1'b1; e.lc = 9'(256 + f3 * 32 + rs2);
      end
      'h37: begin e.imm = 32'(iu); e.ie = 1'b1; e.so = 6'(rd); end
      'h17: begin e.sa = 6'd32; e.imm = 32'(iu); e.ie = 1'b1; e.so = 6'(rd); end
      'h6f: begin
        e.sa = 6'd32; e.imm = -32'sd4; e.ie = 1'b1; e.so = 6'(rd); e.nj = 1'b1; e.jt = 3'd2;
        e.ji = 32'(ij); e.jr = 6'd32;
      end
      'h67: begin
        e.sa = 6'd32; e.imm = -32'sd4; e.ie = 1'b1; e.so = 6'(rd); e.nj = 1'b1; e.jt = 3'd3;
        e.ji = 32'(ii); e.jr = 6'(rs1);
      end
      'h03: begin
        e.sa = 6'(rs1); e.imm = 32'(ii); e.ie = 1'b1; e.so = 6'(rd); e.ln = 1'b1; e.lc = 9'(f3 * 32 + rd);
      end
      'h13: begin
        e.sa = 6'(rs1); e.imm = 32'(ii); e.ie = 1'b1; e.so = 6'(rd); e.alu = 10'(f7 * 8 + f3);
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.il = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  function automatic bit is_jump(input logic [31:0] w);
    return (w[6:0] == 7'h63) || (w[6:0] == 7'h6f) || (w[6:0] == 7'h67);
  endfunction

  // Advance model with the inputs currently driven, then move to 1 time unit past the edge.
  task automatic step();
    bit acc, ld, clr, wj0;
    wj0 = m_wj;
    acc = in_valid && (mq.size() < QD);
    ld  = !m_wj && (mq.size() > 0) && (!m_ov || out_ready);
    clr = m_wj && jmp_resolve && jmp_taken;
    if (flush) begin
      mq.delete(); m_ov = 0; m_wj = 0;
    end else begin
      if (ld) begin
        m_ob = mq.pop_front(); m_ov = 1;
        if (is_jump(m_ob)) m_wj = 1;
      end else if (out_ready) m_ov = 0;
      if (clr) mq.delete();
      else if (acc) mq.push_back(in_instr);
      if (wj0 && jmp_resolve) m_wj = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; jmp_resolve = 0; jmp_taken = 0; out_ready = 0; in_instr = '0;
    rst = 1'b1;
    mq.delete(); m_ov = 0; m_wj = 0; m_ob = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] addi(input int rd, input int val);
    logic [31:0] w;
    w = {12'(val), 5'd0, 3'b000, 5'(rd), 7'h13};
    return w;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    total++; if (act !== exp_t'(0)) begin bad++; $display("FAIL reset_fields got=%h exp=0", act); end
    @(posedge clk); #1 rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    // mid-operation asynchronous reset
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin in_valid = 1; in_instr = addi(i + 1, 100 + i); step(); end
    in_valid = 0;
    #3 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || q_count !== 3'd0 || imm !== 32'd0) begin
      bad++; $display("FAIL async_reset got ov=%b cnt=%0d imm=%h exp ov=0 cnt=0 imm=0", out_valid, q_count, imm);
    end
    @(posedge clk); #1 rst = 1'b0;
    mq.delete(); m_ov = 0; m_wj = 0;
  endtask

  task automatic test_addi();
    do_reset();
    out_ready = 1; in_valid = 1; in_instr = 32'h0050_0093;
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b0 || q_count !== 3'd1) begin
      bad++; $display("FAIL addi_e0 got ov=%b cnt=%0d exp ov=0 cnt=1", out_valid, q_count);
    end
    step();
    total++; if (out_valid !== 1'b1 || imm !== 32'd5 || sel_a !== 6'd0 || sel_out !== 6'd1 ||
                 alu_ctrl !== 10'd0 || imm_en !== 1'b1 || illegal !== 1'b0) begin
      bad++; $display("FAIL addi_fields got ov=%b imm=%h sa=%0d so=%0d alu=%h ie=%b il=%b exp ov=1 imm=5 sa=0 so=1 alu=0 ie=1 il=0",
                      out_valid, imm, sel_a, sel_out, alu_ctrl, imm_en, illegal);
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] arr [6];
    int pushed;
    bit acc;
    do_reset();
    for (int i = 0; i < 6; i++) arr[i] = addi(i + 1, int'($urandom_range(0, 4095)));
    pushed = 0;
    for (int c = 0; c < 12 && pushed < 5; c++) begin
      in_valid = 1; in_instr = arr[pushed]; acc = in_ready; step();
      if (acc) pushed++;
    end
    in_valid = 1; in_instr = arr[5];
    total++; if (in_ready !== 1'b0 || q_count !== 3'd4 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_full got rdy=%b cnt=%0d ov=%b exp rdy=0 cnt=4 ov=1", in_ready, q_count, out_valid);
    end
    step(); step();
    total++; if (act !== ref_dec(arr[0]) || q_count !== 3'd4) begin
      bad++; $display("FAIL bp_hold got=%h cnt=%0d exp=%h cnt=4", act, q_count, ref_dec(arr[0]));
    end
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      total++; if (out_valid !== 1'b1 || act !== ref_dec(arr[k])) begin
        bad++; $display("FAIL bp_issue_%0d got ov=%b %h exp ov=1 %h", k, out_valid, act, ref_dec(arr[k]));
      end
      in_valid = (pushed < 6); in_instr = arr[(pushed < 6) ? pushed : 5];
      acc = in_valid && in_ready; step();
      if (acc) pushed++;
    end
    in_valid = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_branch();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_instr = 32'h0020_8463; step();
    in_instr = 32'h0020_81B3; step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || imm !== 32'd8 || alu_ctrl !== 10'b0100000000 ||
                 new_jmp !== 1'b1 || sel_out !== 6'd0) begin
      bad++; $display("FAIL beq_fields got ov=%b imm=%h alu=%b nj=%b so=%0d exp ov=1 imm=8 alu=0100000000 nj=1 so=0",
                      out_valid, imm, alu_ctrl, new_jmp, sel_out);
    end
    step(); step(); step();
    total++; if (out_valid !== 1'b0 || q_count !== 3'd1) begin
      bad++; $display("FAIL beq_hold got ov=%b cnt=%0d exp ov=0 cnt=1", out_valid, q_count);
    end
    jmp_resolve = 1; jmp_taken = 0; step();
    jmp_resolve = 0;
    total++; if (out_valid !== 1'b0 || q_count !== 3'd1) begin
      bad++; $display("FAIL beq_resolve got ov=%b cnt=%0d exp ov=0 cnt=1", out_valid, q_count);
    end
    step();
    total++; if (out_valid !== 1'b1 || sel_out !== 6'd3 || alu_ctrl !== 10'd0 || q_count !== 3'd0) begin
      bad++; $display("FAIL beq_add got ov=%b so=%0d alu=%h cnt=%0d exp ov=1 so=3 alu=0 cnt=0", out_valid, sel_out, alu_ctrl, q_count);
    end
  endtask

  task automatic test_jal_taken();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_instr = 32'h0080_00EF; step();
    in_instr = addi(5, 11); step();
    total++; if (out_valid !== 1'b1 || jmp_imm !== 32'd8 || jal_rs !== 6'd32 || sel_a !== 6'd32 ||
                 imm !== 32'hFFFF_FFFC || jmp_type !== 3'b010) begin
      bad++; $display("FAIL jal_fields got ov=%b ji=%h jr=%0d sa=%0d imm=%h jt=%b exp ov=1 ji=8 jr=32 sa=32 imm=fffffffc jt=010",
                      out_valid, jmp_imm, jal_rs, sel_a, imm, jmp_type);
    end
    in_instr = addi(6, 12); step();
    in_valid = 0;
    total++; if (q_count !== 3'd2 || out_valid !== 1'b0) begin
      bad++; $display("FAIL jal_queued got cnt=%0d ov=%b exp cnt=2 ov=0", q_count, out_valid);
    end
    jmp_resolve = 1; jmp_taken = 1; step();
    jmp_resolve = 0; jmp_taken = 0;
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL jal_clear got cnt=%0d exp=0", q_count); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL jal_no_issue_%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_instr = 32'h0080_00EF; step();
    for (int i = 0; i < 3; i++) begin in_instr = addi(i + 1, i); step(); end
    total++; if (q_count !== 3'd3 || out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_pre got cnt=%0d ov=%b exp cnt=3 ov=1", q_count, out_valid);
    end
    flush = 1; in_valid = 1; in_instr = addi(9, 99); step();
    flush = 0; in_valid = 0;
    total++; if (q_count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear got cnt=%0d ov=%b exp cnt=0 ov=0", q_count, out_valid);
    end
    out_ready = 1; in_valid = 1; in_instr = addi(7, 77); step();
    in_valid = 0; step();
    total++; if (out_valid !== 1'b1 || sel_out !== 6'd7 || imm !== 32'd77) begin
      bad++; $display("FAIL flush_run got ov=%b so=%0d imm=%h exp ov=1 so=7 imm=4d", out_valid, sel_out, imm);
    end
    step();
    total++; if (out_valid !== 1'b0 || q_count !== 3'd0) begin
      bad++; $display("FAIL flush_dropped got ov=%b cnt=%0d exp ov=0 cnt=0", out_valid, q_count);
    end
  endtask

  task automatic test_illegal();
    logic exp_il;
`ifdef DECODE_ILLEGAL_TRAP_EN
    exp_il = 1'b1;
`else
    exp_il = 1'b0;
`endif
    do_reset();
    out_ready = 1;
    in_valid = 1; in_instr = 32'hFFFF_FFFF; step();
    in_instr = 32'h0220_81B3; step();
    total++; if (out_valid !== 1'b1 || illegal !== exp_il || sel_out !== 6'd0 || new_jmp !== 1'b0) begin
      bad++; $display("FAIL illegal_ffff got ov=%b il=%b so=%0d nj=%b exp ov=1 il=%b so=0 nj=0", out_valid, illegal, sel_out, new_jmp, exp_il);
    end
    in_instr = addi(4, 44); step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || illegal !== exp_il || sel_out !== (exp_il ? 6'd0 : 6'd3)) begin
      bad++; $display("FAIL illegal_f7 got ov=%b il=%b so=%0d exp ov=1 il=%b so=%0d", out_valid, illegal, sel_out, exp_il, exp_il ? 0 : 3);
    end
    step();
    total++; if (out_valid !== 1'b1 || sel_out !== 6'd4 || illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_next got ov=%b so=%0d il=%b exp ov=1 so=4 il=0", out_valid, sel_out, illegal);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    int          k;
    ops = '{7'h33, 7'h63, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13};
    w = $urandom;
    k = int'($urandom_range(0, 9));
    if (k < 9) w[6:0] = ops[k];
    if (w[6:0] == 7'h33 && ($urandom % 4) != 0) w[31:25] = ($urandom % 2) ? 7'h00 : 7'h20;
    return w;
  endfunction

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom % 3) != 0;
      in_instr    = rand_instr();
      out_ready   = ($urandom % 4) != 0;
      flush       = ($urandom % 60) == 0;
      jmp_resolve = m_wj ? (($urandom % 4) == 0) : (($urandom % 20) == 0);
      jmp_taken   = $urandom % 2;
      step();
      total++; if (out_valid !== m_ov || q_count !== 3'(mq.size()) || in_ready !== (mq.size() < QD)) begin
        bad++; $display("FAIL rand_ctrl_%0d got ov=%b cnt=%0d rdy=%b exp ov=%b cnt=%0d", c, out_valid, q_count, in_ready, m_ov, mq.size());
      end
      if (m_ov) begin
        total++; if (act !== ref_dec(m_ob)) begin
          bad++; $display("FAIL rand_dec_%0d instr=%h got=%h exp=%h", c, m_ob, act, ref_dec(m_ob));
        end
      end
    end
    in_valid = 0; flush = 0; jmp_resolve = 0; jmp_taken = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_branch();
    test_jal_taken();
    test_flush();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
